// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch/jump resolution with registered redirect and timed flush window.
// Optional: define BRU_STATS_EN for branch/taken/jump counters.  Rev 1.0
`default_nettype none

module branch_resolve_unit #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ex_valid,
  input  logic        i_stall,
  input  logic        i_is_br,
  input  logic        i_is_jal,
  input  logic        i_is_jalr,
  input  logic [2:0]  i_funct3,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1_data,
  output logic        o_br_un,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic        o_illegal_br,
  output logic        o_misalign
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] o_cnt_br,
  output logic [31:0] o_cnt_taken,
  output logic [31:0] o_cnt_jump
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state, state_next;
  logic [2:0]  count, count_next;
  logic [31:0] target_q;
  logic        illegal_q;

  logic        accept, sel_jalr, sel_jal, sel_br, br_legal, br_cond, br_taken, take;
  logic [31:0] pc_sum, jalr_sum, target;

  assign o_br_un = i_funct3[1];

  // Precedence jalr > jal > br when several type flags are set.
  assign accept   = i_ex_valid & ~i_stall & (state == IDLE);
  assign sel_jalr = i_is_jalr;
  assign sel_jal  = ~i_is_jalr & i_is_jal;
  assign sel_br   = ~i_is_jalr & ~i_is_jal & i_is_br;
  assign br_legal = (i_funct3[2:1] != 2'b01);

  always_comb begin
    br_cond = 1'b0;
    case (i_funct3)
      3'b000:          br_cond = i_br_equal;
      3'b001:          br_cond = ~i_br_equal;
      3'b100, 3'b110:  br_cond = i_br_less;
      3'b101, 3'b111:  br_cond = ~i_br_less;
      default:         br_cond = 1'b0;
    endcase
  end

  assign br_taken = sel_br & br_legal & br_cond;
  assign take     = accept & (sel_jalr | sel_jal | br_taken);
  assign pc_sum   = i_ex_pc + i_imm;
  assign jalr_sum = i_rs1_data + i_imm;
  assign target   = sel_jalr ? (jalr_sum & ~32'h1) : pc_sum;

  always_comb begin
    state_next       = state;
    count_next       = count;
    o_redirect_valid = 1'b0;
    o_flush          = 1'b0;
    o_misalign       = 1'b0;
    case (state)
      IDLE: begin
        if (take) state_next = REDIRECT;
      end
      REDIRECT: begin
        o_redirect_valid = 1'b1;
        o_flush          = 1'b1;
        o_misalign       = target_q[1] | target_q[0];
        count_next       = CNT_INIT;
        state_next       = (CNT_INIT != 3'd0) ? FLUSH : IDLE;
      end
      FLUSH: begin
        o_flush    = 1'b1;
        count_next = count - 3'd1;
        if (count <= 3'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      count     <= 3'd0;
      target_q  <= RESET_PC;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      illegal_q <= accept & sel_br & ~br_legal;
      if (take) target_q <= target;
    end
  end

  assign o_redirect_pc = target_q;
  assign o_illegal_br  = illegal_q;

`ifdef BRU_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_cnt_br    <= 32'd0;
      o_cnt_taken <= 32'd0;
      o_cnt_jump  <= 32'd0;
    end else begin
      if (accept & sel_br & br_legal)     o_cnt_br    <= o_cnt_br + 32'd1;
      if (accept & br_taken)              o_cnt_taken <= o_cnt_taken + 32'd1;
      if (accept & (sel_jal | sel_jalr))  o_cnt_jump  <= o_cnt_jump + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors for branch_resolve_unit (RESET_PC=32'h100, FLUSH_CYCLES=2).
`default_nettype none

module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset, ex_valid, stall, is_br, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic        br_less, br_equal;
  logic [31:0] ex_pc, imm, rs1_data;
  logic        br_un, redirect_valid, flush, illegal_br, misalign;
  logic [31:0] redirect_pc;
`ifdef BRU_STATS_EN
  logic [31:0] cnt_br, cnt_taken, cnt_jump;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.FLUSH_CYCLES(2), .RESET_PC(32'h100)) dut (
    .i_clk(clk), .i_reset(reset), .i_ex_valid(ex_valid), .i_stall(stall),
    .i_is_br(is_br), .i_is_jal(is_jal), .i_is_jalr(is_jalr), .i_funct3(funct3),
    .i_br_less(br_less), .i_br_equal(br_equal), .i_ex_pc(ex_pc), .i_imm(imm),
    .i_rs1_data(rs1_data), .o_br_un(br_un), .o_redirect_valid(redirect_valid),
    .o_redirect_pc(redirect_pc), .o_flush(flush), .o_illegal_br(illegal_br),
    .o_misalign(misalign)
`ifdef BRU_STATS_EN
    , .o_cnt_br(cnt_br), .o_cnt_taken(cnt_taken), .o_cnt_jump(cnt_jump)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; stall = 0; is_br = 0; is_jal = 0; is_jalr = 0;
    funct3 = 3'b000; br_less = 0; br_equal = 0;
    ex_pc = 32'h0; imm = 32'h0; rs1_data = 32'h0;
  endtask

  task automatic drive_br(input logic [2:0] f3, input logic lt, input logic eq,
                          input logic [31:0] pc, input logic [31:0] im);
    clear_ex();
    ex_valid = 1; is_br = 1; funct3 = f3; br_less = lt; br_equal = eq;
    ex_pc = pc; imm = im;
  endtask

  initial begin
    clear_ex();
    reset = 1;
    step(); step();
    check("rst_rv",    {31'd0, redirect_valid}, 32'd0);
    check("rst_flush", {31'd0, flush},          32'd0);
    check("rst_ill",   {31'd0, illegal_br},     32'd0);
    check("rst_mis",   {31'd0, misalign},       32'd0);
    check("rst_pc",    redirect_pc,             32'h100);
`ifdef BRU_STATS_EN
    check("rst_cnt_br", cnt_br, 32'd0);
`endif
    reset = 0;
    step();

    // BEQ taken: redirect next cycle, flush exactly two cycles
    drive_br(3'b000, 0, 1, 32'h40, 32'h10);
    step();
    check("beq_rv",     {31'd0, redirect_valid}, 32'd1);
    check("beq_pc",     redirect_pc,             32'h50);
    check("beq_flush1", {31'd0, flush},          32'd1);
    check("beq_mis",    {31'd0, misalign},       32'd0);
    clear_ex();
    step();
    check("beq_rv2",    {31'd0, redirect_valid}, 32'd0);
    check("beq_flush2", {31'd0, flush},          32'd1);
    step();
    check("beq_flush3", {31'd0, flush},          32'd0);

    // BEQ not taken
    drive_br(3'b000, 0, 0, 32'h80, 32'h10);
    step();
    check("beqnt_rv",    {31'd0, redirect_valid}, 32'd0);
    check("beqnt_flush", {31'd0, flush},          32'd0);
    check("beqnt_pc",    redirect_pc,             32'h50);
    clear_ex();
    step();

    // BLTU taken, unsigned select
    drive_br(3'b110, 1, 0, 32'h200, 32'h20);
    #1;
    check("bltu_un", {31'd0, br_un}, 32'd1);
    step();
    check("bltu_rv", {31'd0, redirect_valid}, 32'd1);
    check("bltu_pc", redirect_pc,             32'h220);
    clear_ex();
    step(); step();

    // BGE with less=1: not taken, signed select
    drive_br(3'b101, 1, 0, 32'h240, 32'h20);
    #1;
    check("bge_un", {31'd0, br_un}, 32'd0);
    step();
    check("bge_rv", {31'd0, redirect_valid}, 32'd0);
    clear_ex();
    step();

    // JALR: (rs1+imm)&~1, misaligned
    clear_ex();
    ex_valid = 1; is_jalr = 1; rs1_data = 32'h1003; imm = 32'h4; ex_pc = 32'h900;
    step();
    check("jalr_rv",  {31'd0, redirect_valid}, 32'd1);
    check("jalr_pc",  redirect_pc,             32'h1006);
    check("jalr_mis", {31'd0, misalign},       32'd1);
    clear_ex();
    step();
    check("jalr_mis2", {31'd0, misalign}, 32'd0);
    step();

    // JAL wrap-around
    clear_ex();
    ex_valid = 1; is_jal = 1; ex_pc = 32'hFFFF_FFFC; imm = 32'h8;
    step();
    check("jal_rv",  {31'd0, redirect_valid}, 32'd1);
    check("jal_pc",  redirect_pc,             32'h4);
    check("jal_mis", {31'd0, misalign},       32'd0);
    clear_ex();
    step(); step();

    // Taken BNE, then a taken JAL arrives in the flush window: ignored
    drive_br(3'b001, 0, 0, 32'h300, 32'h40);
    step();
    check("bne_rv", {31'd0, redirect_valid}, 32'd1);
    check("bne_pc", redirect_pc,             32'h340);
    clear_ex();
    ex_valid = 1; is_jal = 1; ex_pc = 32'h500; imm = 32'h100;
    step();
    check("wp_rv",    {31'd0, redirect_valid}, 32'd0);
    check("wp_flush", {31'd0, flush},          32'd1);
    clear_ex();
    step();
    check("wp_rv2", {31'd0, redirect_valid}, 32'd0);
    check("wp_pc",  redirect_pc,             32'h340);

    // Stall defers the decision
    drive_br(3'b000, 0, 1, 32'h600, 32'h8);
    stall = 1;
    step(); step();
    check("stall_rv",    {31'd0, redirect_valid}, 32'd0);
    check("stall_flush", {31'd0, flush},          32'd0);
    stall = 0;
    step();
    check("unstall_rv", {31'd0, redirect_valid}, 32'd1);
    check("unstall_pc", redirect_pc,             32'h608);
    clear_ex();
    step(); step();

    // Illegal funct3
    drive_br(3'b010, 1, 1, 32'h700, 32'h4);
    step();
    check("ill_pulse", {31'd0, illegal_br},     32'd1);
    check("ill_rv",    {31'd0, redirect_valid}, 32'd0);
    check("ill_flush", {31'd0, flush},          32'd0);
    clear_ex();
    step();
    check("ill_pulse2", {31'd0, illegal_br}, 32'd0);

    // Reset mid-flush
    drive_br(3'b000, 0, 1, 32'h40, 32'h10);
    step();
    check("pre_rst_flush", {31'd0, flush}, 32'd1);
    clear_ex();
    reset = 1;
    step();
    check("midrst_flush", {31'd0, flush},          32'd0);
    check("midrst_rv",    {31'd0, redirect_valid}, 32'd0);
    check("midrst_pc",    redirect_pc,             32'h100);
    reset = 0;
    step();
    check("postrst_flush", {31'd0, flush}, 32'd0);

`ifdef BRU_STATS_EN
    // 3 legal branches (2 taken) + 1 JAL
    drive_br(3'b000, 0, 1, 32'h40, 32'h10);
    step(); clear_ex(); step(); step();
    drive_br(3'b000, 0, 0, 32'h40, 32'h10);
    step();
    drive_br(3'b001, 0, 0, 32'h40, 32'h10);
    step(); clear_ex(); step(); step();
    clear_ex();
    ex_valid = 1; is_jal = 1; ex_pc = 32'h40; imm = 32'h8;
    step(); clear_ex(); step(); step();
    check("cnt_br",    cnt_br,    32'd3);
    check("cnt_taken", cnt_taken, 32'd2);
    check("cnt_jump",  cnt_jump,  32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
